npu_mem_arbiter: RTL and testbench

Parametrised two-master, N-bank SRAM access arbiter for the NPU system. It is the successor to the fixed SPI-over-tile-processor write mux. The host port is SPI-command driven and the engine port is tile-processor driven; both can read and write any bank. Arbitration is per bank, priority is selectable, a starvation guard bounds waiting, and read data returns on a tagged valid strobe.

---
 rtl/npu_mem_arbiter_if.sv | 19 +
 rtl/npu_mem_arbiter.sv | 177 +++++++++++++++++
 tb/tb_npu_mem_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/npu_mem_arbiter_if.sv
// One requester port of the NPU memory arbiter: request fields toward the
// arbiter, grant and tagged read return back to the requester.
interface npu_mem_arbiter_if #(
   parameter int BANK_W = 2,
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8
);
   logic              req;
   logic              we;
   logic [BANK_W-1:0] bank;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              gnt;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;

   modport master (output req, we, bank, addr, wdata, input gnt, rvalid, rdata);
   modport slave  (input req, we, bank, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/npu_mem_arbiter.sv
// Two-master (host, engine), N-bank SRAM arbiter. Grants are combinational and
// per bank; the winning access is registered onto the bank strobes one cycle
// later, and read data comes back on a per-master valid pulse. Out-of-range
// banks are granted but never strobe an SRAM, and return zero data.
module npu_mem_arbiter #(
   parameter int NUM_BANKS  = 3,
   parameter int BANK_W     = 2,
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 8,
   parameter int RD_LAT     = 1,
   parameter int STARVE_MAX = 15
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [1:0]                  mode,
   npu_mem_arbiter_if.slave            host,
   npu_mem_arbiter_if.slave            engine,
   output logic [NUM_BANKS-1:0]        m_ce,
   output logic [NUM_BANKS-1:0]        m_we,
   output logic [NUM_BANKS*ADDR_W-1:0] m_addr,
   output logic [NUM_BANKS*DATA_W-1:0] m_din,
   input  logic [NUM_BANKS*DATA_W-1:0] m_dout,
   output logic                        err_bank,
   output logic [15:0]                 conflict_cnt
);
   typedef enum logic {MASTER_HOST, MASTER_ENGINE} master_t;

   master_t              last_winner;
   logic [7:0]           h_starve;
   logic [7:0]           e_starve;
   logic                 h_oob;
   logic                 e_oob;
   logic                 contested;
   logic                 host_wins;
   logic                 h_gnt;
   logic                 e_gnt;
   logic [NUM_BANKS-1:0] h_hit;
   logic [NUM_BANKS-1:0] e_hit;

   // Read return pipeline, one lane per master so both may read in the same cycle
   logic [RD_LAT:0]      h_pipe_vld;
   logic [RD_LAT:0]      e_pipe_vld;
   logic [RD_LAT:0]      h_pipe_oob;
   logic [RD_LAT:0]      e_pipe_oob;
   logic [BANK_W-1:0]    h_pipe_bank [RD_LAT+1];
   logic [BANK_W-1:0]    e_pipe_bank [RD_LAT+1];
   logic [DATA_W-1:0]    h_ret_data;
   logic [DATA_W-1:0]    e_ret_data;

   // Decide the winner of a same-bank collision and form grants and bank hits
   always_comb begin
      h_oob     = {1'b0, host.bank} >= (BANK_W+1)'(NUM_BANKS);
      e_oob     = {1'b0, engine.bank} >= (BANK_W+1)'(NUM_BANKS);
      contested = host.req & engine.req & (host.bank == engine.bank);
      if (h_starve >= 8'(STARVE_MAX)) begin
         host_wins = 1'b1;
      end else if (e_starve >= 8'(STARVE_MAX)) begin
         host_wins = 1'b0;
      end else begin
         case (mode)
            2'd1:    host_wins = 1'b0;
            2'd2:    host_wins = (last_winner == MASTER_ENGINE);
            default: host_wins = 1'b1;
         endcase
      end
      h_gnt = rst_n & host.req & (~contested | host_wins);
      e_gnt = rst_n & engine.req & (~contested | ~host_wins);
      for (int k = 0; k < NUM_BANKS; k++) begin
         h_hit[k] = h_gnt & ~h_oob & (host.bank == BANK_W'(k));
         e_hit[k] = e_gnt & ~e_oob & (engine.bank == BANK_W'(k));
      end
      host.gnt   = h_gnt;
      engine.gnt = e_gnt;
   end

   // Pick the returning bank's read data at the end of the return pipeline
   always_comb begin
      h_ret_data = '0;
      e_ret_data = '0;
      for (int k = 0; k < NUM_BANKS; k++) begin
         if (!h_pipe_oob[RD_LAT] && h_pipe_bank[RD_LAT] == BANK_W'(k)) begin
            h_ret_data = m_dout[k*DATA_W +: DATA_W];
         end
         if (!e_pipe_oob[RD_LAT] && e_pipe_bank[RD_LAT] == BANK_W'(k)) begin
            e_ret_data = m_dout[k*DATA_W +: DATA_W];
         end
      end
   end

   // Track starvation, round-robin history and the saturating collision count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_starve     <= '0;
         e_starve     <= '0;
         last_winner  <= MASTER_ENGINE;
         conflict_cnt <= '0;
      end else begin
         if (host.req && !h_gnt) begin
            h_starve <= (h_starve == 8'hFF) ? h_starve : h_starve + 8'd1;
         end else begin
            h_starve <= '0;
         end
         if (engine.req && !e_gnt) begin
            e_starve <= (e_starve == 8'hFF) ? e_starve : e_starve + 8'd1;
         end else begin
            e_starve <= '0;
         end
         if (contested) begin
            last_winner <= host_wins ? MASTER_HOST : MASTER_ENGINE;
            if (conflict_cnt != 16'hFFFF) begin
               conflict_cnt <= conflict_cnt + 16'd1;
            end
         end
      end
   end

   // Register granted accesses onto the bank strobes; idle banks keep addr/data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ce     <= '0;
         m_we     <= '0;
         m_addr   <= '0;
         m_din    <= '0;
         err_bank <= 1'b0;
      end else begin
         for (int k = 0; k < NUM_BANKS; k++) begin
            m_ce[k] <= h_hit[k] | e_hit[k];
            m_we[k] <= (h_hit[k] & host.we) | (e_hit[k] & engine.we);
            if (h_hit[k]) begin
               m_addr[k*ADDR_W +: ADDR_W] <= host.addr;
               m_din[k*DATA_W +: DATA_W]  <= host.wdata;
            end else if (e_hit[k]) begin
               m_addr[k*ADDR_W +: ADDR_W] <= engine.addr;
               m_din[k*DATA_W +: DATA_W]  <= engine.wdata;
            end
         end
         err_bank <= (h_gnt & h_oob) | (e_gnt & e_oob);
      end
   end

   // Carry granted reads through the SRAM latency and raise the valid pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_pipe_vld    <= '0;
         e_pipe_vld    <= '0;
         h_pipe_oob    <= '0;
         e_pipe_oob    <= '0;
         for (int i = 0; i <= RD_LAT; i++) begin
            h_pipe_bank[i] <= '0;
            e_pipe_bank[i] <= '0;
         end
         host.rvalid   <= 1'b0;
         host.rdata    <= '0;
         engine.rvalid <= 1'b0;
         engine.rdata  <= '0;
      end else begin
         h_pipe_vld     <= {h_pipe_vld[RD_LAT-1:0], h_gnt & ~host.we};
         e_pipe_vld     <= {e_pipe_vld[RD_LAT-1:0], e_gnt & ~engine.we};
         h_pipe_oob     <= {h_pipe_oob[RD_LAT-1:0], h_oob};
         e_pipe_oob     <= {e_pipe_oob[RD_LAT-1:0], e_oob};
         h_pipe_bank[0] <= host.bank;
         e_pipe_bank[0] <= engine.bank;
         for (int i = 1; i <= RD_LAT; i++) begin
            h_pipe_bank[i] <= h_pipe_bank[i-1];
            e_pipe_bank[i] <= e_pipe_bank[i-1];
         end
         host.rvalid   <= h_pipe_vld[RD_LAT];
         engine.rvalid <= e_pipe_vld[RD_LAT];
         if (h_pipe_vld[RD_LAT]) begin
            host.rdata <= h_ret_data;
         end
         if (e_pipe_vld[RD_LAT]) begin
            engine.rdata <= e_ret_data;
         end
      end
   end
endmodule

// File: tb/tb_npu_mem_arbiter.sv
// Bench for npu_mem_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model (grant rules, memory image, return times).
module tb_npu_mem_arbiter;
   localparam int NUM_BANKS  = 3;
   localparam int BANK_W     = 2;
   localparam int ADDR_W     = 10;
   localparam int DATA_W     = 8;
   localparam int RD_LAT     = 1;
   localparam int STARVE_MAX = 15;

   logic                        clk = 1'b0;
   logic                        rst_n = 1'b0;
   logic [1:0]                  mode = 2'd0;
   logic [NUM_BANKS-1:0]        m_ce;
   logic [NUM_BANKS-1:0]        m_we;
   logic [NUM_BANKS*ADDR_W-1:0] m_addr;
   logic [NUM_BANKS*DATA_W-1:0] m_din;
   logic [NUM_BANKS*DATA_W-1:0] m_dout;
   logic                        err_bank;
   logic [15:0]                 conflict_cnt;
   int                          checks = 0;
   int                          errors = 0;

   npu_mem_arbiter_if #(.BANK_W(BANK_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) host_bus ();
   npu_mem_arbiter_if #(.BANK_W(BANK_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) eng_bus ();

   npu_mem_arbiter #(
      .NUM_BANKS(NUM_BANKS), .BANK_W(BANK_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
      .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .host(host_bus), .engine(eng_bus),
      .m_ce(m_ce), .m_we(m_we), .m_addr(m_addr), .m_din(m_din), .m_dout(m_dout),
      .err_bank(err_bank), .conflict_cnt(conflict_cnt)
   );

   always #5 clk = ~clk;

   // Behavioural SRAM banks with one cycle read latency
   logic [DATA_W-1:0] sram [NUM_BANKS][1<<ADDR_W];
   logic              sram_clear = 1'b1;
   always @(posedge clk) begin
      for (int k = 0; k < NUM_BANKS; k++) begin
         if (sram_clear) begin
            for (int a = 0; a < (1<<ADDR_W); a++) sram[k][a] <= '0;
         end else if (m_ce[k]) begin
            if (m_we[k]) sram[k][m_addr[k*ADDR_W +: ADDR_W]] <= m_din[k*DATA_W +: DATA_W];
            else m_dout[k*DATA_W +: DATA_W] <= sram[k][m_addr[k*ADDR_W +: ADDR_W]];
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      host_bus.req = 1'b0; host_bus.we = 1'b0; host_bus.bank = '0; host_bus.addr = '0; host_bus.wdata = '0;
      eng_bus.req  = 1'b0; eng_bus.we  = 1'b0; eng_bus.bank  = '0; eng_bus.addr  = '0; eng_bus.wdata  = '0;
   endtask

   task automatic host_drive(input logic we, input int bank, input int addr, input int data);
      host_bus.req = 1'b1; host_bus.we = we; host_bus.bank = BANK_W'(bank);
      host_bus.addr = ADDR_W'(addr); host_bus.wdata = DATA_W'(data);
   endtask

   task automatic eng_drive(input logic we, input int bank, input int addr, input int data);
      eng_bus.req = 1'b1; eng_bus.we = we; eng_bus.bank = BANK_W'(bank);
      eng_bus.addr = ADDR_W'(addr); eng_bus.wdata = DATA_W'(data);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle();
      mode = 2'd0;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      host_bus.req = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #2;
      checks++; if (host_bus.gnt !== 1'b0) begin errors++; $display("[TB] FAIL reset_h_gnt: got %0h expected 0", host_bus.gnt); end
      checks++; if ({m_ce, m_we, err_bank} !== '0) begin errors++; $display("[TB] FAIL reset_strobes: got %0h expected 0", {m_ce, m_we, err_bank}); end
      checks++; if ({m_addr, m_din} !== '0) begin errors++; $display("[TB] FAIL reset_bus: got %0h expected 0", {m_addr, m_din}); end
      checks++; if (conflict_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_conflict: got %0h expected 0", conflict_cnt); end
      checks++; if ({host_bus.rvalid, host_bus.rdata, eng_bus.rvalid, eng_bus.rdata, eng_bus.gnt} !== '0) begin
         errors++; $display("[TB] FAIL reset_return: got %0h expected 0", {host_bus.rvalid, host_bus.rdata, eng_bus.rvalid, eng_bus.rdata, eng_bus.gnt});
      end
      sram_clear = 1'b0;
      idle();
      #1 rst_n = 1'b1;
   endtask

   task automatic test_write_read();
      do_reset();
      tick(); host_drive(1'b1, 1, 'h005, 'hA5); #1;
      checks++; if (host_bus.gnt !== 1'b1) begin errors++; $display("[TB] FAIL wr_gnt: got %0h expected 1", host_bus.gnt); end
      tick(); idle(); #1;
      checks++; if (m_ce !== 3'b010 || m_we !== 3'b010) begin errors++; $display("[TB] FAIL wr_strobe: got ce=%0b we=%0b expected ce=010 we=010", m_ce, m_we); end
      checks++; if (m_addr[ADDR_W +: ADDR_W] !== 10'h005 || m_din[DATA_W +: DATA_W] !== 8'hA5) begin
         errors++; $display("[TB] FAIL wr_bus: got addr=%0h din=%0h expected 5 a5", m_addr[ADDR_W +: ADDR_W], m_din[DATA_W +: DATA_W]);
      end
      tick(); host_drive(1'b0, 1, 'h005, 0); #1;
      checks++; if (host_bus.gnt !== 1'b1) begin errors++; $display("[TB] FAIL rd_gnt: got %0h expected 1", host_bus.gnt); end
      tick(); idle(); #1;
      checks++; if (m_ce !== 3'b010 || m_we !== 3'b000) begin errors++; $display("[TB] FAIL rd_strobe: got ce=%0b we=%0b expected ce=010 we=000", m_ce, m_we); end
      tick(); #1;
      checks++; if (host_bus.rvalid !== 1'b0) begin errors++; $display("[TB] FAIL rd_early: got %0h expected 0", host_bus.rvalid); end
      tick(); #1;
      checks++; if (host_bus.rvalid !== 1'b1 || host_bus.rdata !== 8'hA5) begin
         errors++; $display("[TB] FAIL rd_return: got v=%0h d=%0h expected v=1 d=a5", host_bus.rvalid, host_bus.rdata);
      end
      tick(); #1;
      checks++; if (host_bus.rvalid !== 1'b0 || host_bus.rdata !== 8'hA5) begin
         errors++; $display("[TB] FAIL rd_hold: got v=%0h d=%0h expected v=0 d=a5", host_bus.rvalid, host_bus.rdata);
      end
   endtask

   task automatic test_parallel();
      do_reset();
      tick(); host_drive(1'b1, 0, 'h011, 'h12); eng_drive(1'b0, 2, 'h022, 0); #1;
      checks++; if (host_bus.gnt !== 1'b1 || eng_bus.gnt !== 1'b1) begin
         errors++; $display("[TB] FAIL par_gnt: got h=%0h e=%0h expected 1 1", host_bus.gnt, eng_bus.gnt);
      end
      tick(); idle(); #1;
      checks++; if (m_ce !== 3'b101 || m_we !== 3'b001) begin errors++; $display("[TB] FAIL par_ce: got ce=%0b we=%0b expected ce=101 we=001", m_ce, m_we); end
      checks++; if (conflict_cnt !== 16'd0) begin errors++; $display("[TB] FAIL par_conflict: got %0d expected 0", conflict_cnt); end
   endtask

   task automatic test_contention();
      do_reset();
      tick(); mode = 2'd0; host_drive(1'b0, 1, 'h030, 0); eng_drive(1'b0, 1, 'h031, 0); #1;
      checks++; if (host_bus.gnt !== 1'b1 || eng_bus.gnt !== 1'b0) begin
         errors++; $display("[TB] FAIL host_first: got h=%0h e=%0h expected 1 0", host_bus.gnt, eng_bus.gnt);
      end
      tick(); mode = 2'd1; host_drive(1'b0, 1, 'h032, 0); #1;
      checks++; if (host_bus.gnt !== 1'b0 || eng_bus.gnt !== 1'b1) begin
         errors++; $display("[TB] FAIL engine_first: got h=%0h e=%0h expected 0 1", host_bus.gnt, eng_bus.gnt);
      end
      do_reset();
      for (int i = 0; i < 4; i++) begin
         tick(); mode = 2'd2; host_drive(1'b0, 1, 'h040 + i, 0); eng_drive(1'b0, 1, 'h050 + i, 0); #1;
         checks++; if (host_bus.gnt !== logic'(i % 2 == 0) || eng_bus.gnt !== logic'(i % 2 == 1)) begin
            errors++; $display("[TB] FAIL rr_%0d: got h=%0h e=%0h expected h=%0d", i, host_bus.gnt, eng_bus.gnt, i % 2 == 0);
         end
      end
      tick(); idle(); #1;
      checks++; if (conflict_cnt !== 16'd4) begin errors++; $display("[TB] FAIL rr_conflict: got %0d expected 4", conflict_cnt); end
   endtask

   task automatic test_starvation();
      int first;
      first = 0;
      do_reset();
      eng_drive(1'b0, 0, 'h020, 0);
      for (int n = 1; n <= 40 && first == 0; n++) begin
         tick(); host_drive(1'b0, 0, n, 0); #1;
         if (eng_bus.gnt === 1'b1) first = n;
         else begin
            checks++; if (host_bus.gnt !== 1'b1) begin errors++; $display("[TB] FAIL starve_host_%0d: got %0h expected 1", n, host_bus.gnt); end
         end
      end
      checks++; if (first != STARVE_MAX + 1) begin errors++; $display("[TB] FAIL starve_cycle: got %0d expected %0d", first, STARVE_MAX + 1); end
      checks++; if (host_bus.gnt !== 1'b0) begin errors++; $display("[TB] FAIL starve_host_denied: got %0h expected 0", host_bus.gnt); end
      tick(); idle();
   endtask

   task automatic test_bad_bank();
      do_reset();
      tick(); eng_drive(1'b1, 2, 'h009, 'h3C); #1;
      tick(); idle(); tick();
      tick(); eng_drive(1'b0, 2, 'h009, 0); #1;
      tick(); idle(); tick(); tick(); #1;
      checks++; if (eng_bus.rvalid !== 1'b1 || eng_bus.rdata !== 8'h3C) begin
         errors++; $display("[TB] FAIL eng_read: got v=%0h d=%0h expected v=1 d=3c", eng_bus.rvalid, eng_bus.rdata);
      end
      tick(); eng_drive(1'b0, 3, 'h007, 0); #1;
      checks++; if (eng_bus.gnt !== 1'b1) begin errors++; $display("[TB] FAIL oob_gnt: got %0h expected 1", eng_bus.gnt); end
      tick(); idle(); #1;
      checks++; if (m_ce !== 3'b000 || err_bank !== 1'b1) begin errors++; $display("[TB] FAIL oob_issue: got ce=%0b err=%0h expected 000 1", m_ce, err_bank); end
      tick(); #1;
      checks++; if (err_bank !== 1'b0 || eng_bus.rvalid !== 1'b0) begin
         errors++; $display("[TB] FAIL oob_pulse: got err=%0h v=%0h expected 0 0", err_bank, eng_bus.rvalid);
      end
      tick(); #1;
      checks++; if (eng_bus.rvalid !== 1'b1 || eng_bus.rdata !== 8'h00 || host_bus.rvalid !== 1'b0) begin
         errors++; $display("[TB] FAIL oob_return: got v=%0h d=%0h hv=%0h expected 1 0 0", eng_bus.rvalid, eng_bus.rdata, host_bus.rvalid);
      end
   endtask

   task automatic test_reset_flush();
      int seen;
      seen = 0;
      do_reset();
      tick(); host_drive(1'b0, 1, 'h005, 0); #1;
      tick(); idle(); tick(); tick(); #1;
      checks++; if (host_bus.rdata !== 8'hA5) begin errors++; $display("[TB] FAIL flush_pre: got %0h expected a5", host_bus.rdata); end
      tick(); host_drive(1'b0, 1, 'h005, 0); eng_drive(1'b0, 1, 'h006, 0); #1;
      checks++; if (host_bus.gnt !== 1'b1) begin errors++; $display("[TB] FAIL flush_gnt: got %0h expected 1", host_bus.gnt); end
      tick(); rst_n = 1'b0; idle(); #1;
      checks++; if ({m_ce, m_we, err_bank, m_addr, m_din, conflict_cnt} !== '0) begin
         errors++; $display("[TB] FAIL flush_outputs: got %0h expected 0", {m_ce, m_we, err_bank, m_addr, m_din, conflict_cnt});
      end
      checks++; if ({host_bus.rvalid, host_bus.rdata, eng_bus.rvalid, eng_bus.rdata} !== '0) begin
         errors++; $display("[TB] FAIL flush_return: got %0h expected 0", {host_bus.rvalid, host_bus.rdata, eng_bus.rvalid, eng_bus.rdata});
      end
      tick(); rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (host_bus.rvalid !== 1'b0 || eng_bus.rvalid !== 1'b0) seen++;
      end
      checks++; if (seen != 0) begin errors++; $display("[TB] FAIL flush_rvalid: got %0d pulses expected 0", seen); end
   endtask

   task automatic test_random();
      int                   h_st, e_st, conflicts, hb, eb;
      bit                   lw_engine, contested, hwin, exp_h, exp_e, exp_err, nxt_err;
      logic [NUM_BANKS-1:0] exp_ce, exp_we, nxt_ce, nxt_we;
      logic [ADDR_W-1:0]    exp_addr [NUM_BANKS];
      logic [DATA_W-1:0]    exp_din [NUM_BANKS];
      logic [DATA_W-1:0]    mdl [NUM_BANKS][8];
      bit                   sv_h [8];
      bit                   sv_e [8];
      logic [DATA_W-1:0]    sd_h [8];
      logic [DATA_W-1:0]    sd_e [8];
      h_st = 0; e_st = 0; conflicts = 0; lw_engine = 1'b1; exp_h = 1'b0; exp_e = 1'b0;
      exp_ce = '0; exp_we = '0; exp_err = 1'b0;
      for (int k = 0; k < NUM_BANKS; k++) begin
         exp_addr[k] = '0; exp_din[k] = '0;
         for (int a = 0; a < 8; a++) mdl[k][a] = '0;
      end
      for (int s = 0; s < 8; s++) begin sv_h[s] = 1'b0; sv_e[s] = 1'b0; sd_h[s] = '0; sd_e[s] = '0; end
      do_reset();
      for (int c = 0; c < 400; c++) begin
         tick();
         if (c >= 395) idle();
         else begin
            if (!(host_bus.req && !exp_h)) begin
               if ($urandom_range(0, 99) < 70) host_drive(1'($urandom_range(0, 1)), $urandom_range(0, 3), 'h100 + $urandom_range(0, 7), $urandom_range(0, 255));
               else host_bus.req = 1'b0;
            end
            if (!(eng_bus.req && !exp_e)) begin
               if ($urandom_range(0, 99) < 70) eng_drive(1'($urandom_range(0, 1)), $urandom_range(0, 3), 'h100 + $urandom_range(0, 7), $urandom_range(0, 255));
               else eng_bus.req = 1'b0;
            end
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
         end
         #1;
         hb = int'(host_bus.bank);
         eb = int'(eng_bus.bank);
         contested = host_bus.req && eng_bus.req && hb == eb;
         if (h_st >= STARVE_MAX) hwin = 1'b1;
         else if (e_st >= STARVE_MAX) hwin = 1'b0;
         else if (mode == 2'd1) hwin = 1'b0;
         else if (mode == 2'd2) hwin = lw_engine;
         else hwin = 1'b1;
         exp_h = host_bus.req && (!contested || hwin);
         exp_e = eng_bus.req && (!contested || !hwin);
         checks++; if (host_bus.gnt !== exp_h || eng_bus.gnt !== exp_e) begin
            errors++; $display("[TB] FAIL rnd_gnt c=%0d: got h=%0h e=%0h expected h=%0h e=%0h", c, host_bus.gnt, eng_bus.gnt, exp_h, exp_e);
         end
         checks++; if (m_ce !== exp_ce || m_we !== exp_we || err_bank !== exp_err) begin
            errors++; $display("[TB] FAIL rnd_issue c=%0d: got ce=%0b we=%0b err=%0h expected ce=%0b we=%0b err=%0h", c, m_ce, m_we, err_bank, exp_ce, exp_we, exp_err);
         end
         for (int k = 0; k < NUM_BANKS; k++) begin
            if (exp_ce[k]) begin
               checks++; if (m_addr[k*ADDR_W +: ADDR_W] !== exp_addr[k] || (exp_we[k] && m_din[k*DATA_W +: DATA_W] !== exp_din[k])) begin
                  errors++; $display("[TB] FAIL rnd_bus c=%0d bank=%0d: got a=%0h d=%0h expected a=%0h d=%0h", c, k, m_addr[k*ADDR_W +: ADDR_W], m_din[k*DATA_W +: DATA_W], exp_addr[k], exp_din[k]);
               end
            end
         end
         checks++; if (host_bus.rvalid !== sv_h[c % 8] || (sv_h[c % 8] && host_bus.rdata !== sd_h[c % 8])) begin
            errors++; $display("[TB] FAIL rnd_h_ret c=%0d: got v=%0h d=%0h expected v=%0h d=%0h", c, host_bus.rvalid, host_bus.rdata, sv_h[c % 8], sd_h[c % 8]);
         end
         checks++; if (eng_bus.rvalid !== sv_e[c % 8] || (sv_e[c % 8] && eng_bus.rdata !== sd_e[c % 8])) begin
            errors++; $display("[TB] FAIL rnd_e_ret c=%0d: got v=%0h d=%0h expected v=%0h d=%0h", c, eng_bus.rvalid, eng_bus.rdata, sv_e[c % 8], sd_e[c % 8]);
         end
         sv_h[c % 8] = 1'b0;
         sv_e[c % 8] = 1'b0;
         nxt_ce = '0; nxt_we = '0;
         nxt_err = (exp_h && hb >= NUM_BANKS) || (exp_e && eb >= NUM_BANKS);
         if (exp_h) begin
            if (hb < NUM_BANKS) begin
               nxt_ce[hb] = 1'b1; nxt_we[hb] = host_bus.we;
               exp_addr[hb] = host_bus.addr; exp_din[hb] = host_bus.wdata;
            end
            if (!host_bus.we) begin
               sv_h[(c + 3) % 8] = 1'b1;
               sd_h[(c + 3) % 8] = (hb < NUM_BANKS) ? mdl[hb][int'(host_bus.addr) - 'h100] : '0;
            end
         end
         if (exp_e) begin
            if (eb < NUM_BANKS) begin
               nxt_ce[eb] = 1'b1; nxt_we[eb] = eng_bus.we;
               exp_addr[eb] = eng_bus.addr; exp_din[eb] = eng_bus.wdata;
            end
            if (!eng_bus.we) begin
               sv_e[(c + 3) % 8] = 1'b1;
               sd_e[(c + 3) % 8] = (eb < NUM_BANKS) ? mdl[eb][int'(eng_bus.addr) - 'h100] : '0;
            end
         end
         if (exp_h && host_bus.we && hb < NUM_BANKS) mdl[hb][int'(host_bus.addr) - 'h100] = host_bus.wdata;
         if (exp_e && eng_bus.we && eb < NUM_BANKS) mdl[eb][int'(eng_bus.addr) - 'h100] = eng_bus.wdata;
         h_st = (host_bus.req && !exp_h) ? h_st + 1 : 0;
         e_st = (eng_bus.req && !exp_e) ? e_st + 1 : 0;
         if (contested) begin
            lw_engine = !hwin;
            conflicts++;
         end
         exp_ce = nxt_ce; exp_we = nxt_we; exp_err = nxt_err;
      end
      checks++; if (conflict_cnt !== 16'(conflicts)) begin errors++; $display("[TB] FAIL rnd_conflict: got %0d expected %0d", conflict_cnt, conflicts); end
   endtask

   // Watchdog so a stuck run still ends with a reported failure
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] timeout");
   end

   // Run every scenario in turn and print the summary
   initial begin
      idle();
      test_reset();
      test_write_read();
      test_parallel();
      test_contention();
      test_starvation();
      test_bad_bank();
      test_reset_flush();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
